mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the single datamemory/peripheral bus (address, write data, read/write strobes) between two requesters: the CPU MEM stage and a DMA/loader port.
- Sits between the MEM stage outputs and the datamemory/peripheralcontrol pair.
- Issues a stall request to CTRL when the CPU loses arbitration.
- CPU has default priority; a DMA burst limit and a starvation counter bound the wait on both sides.

Parameters:
ADDR_W, 32, bus address width
DATA_W, 32, bus data width
MAX_BURST, 4, max consecutive DMA grants won while CPU idle (>=1)
STARVE_LIMIT, 3, denied DMA-request cycles before DMA is forced one slot (>=1)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
cpu_re_i  in  1  CPU read strobe (MEM stage)
cpu_we_i  in  1  CPU write strobe
cpu_addr_i  in  ADDR_W  CPU address
cpu_wdata_i  in  DATA_W  CPU write data
cpu_rdata_o  out  DATA_W  CPU read data, combinational from bus_rdata_i
cpu_stallreq_o  out  1  to CTRL: CPU request not granted this cycle
dma_re_i  in  1  DMA read strobe
dma_we_i  in  1  DMA write strobe
dma_addr_i  in  ADDR_W  DMA address
dma_wdata_i  in  DATA_W  DMA write data
dma_gnt_o  out  1  DMA access performed this cycle
dma_rdata_o  out  DATA_W  registered DMA read data
dma_rvalid_o  out  1  dma_rdata_o valid (1-cycle pulse)
bus_re_o  out  1  to memory/peripheral read enable
bus_we_o  out  1  to memory/peripheral write enable
bus_addr_o  out  ADDR_W  shared address
bus_wdata_o  out  DATA_W  shared write data
bus_rdata_i  in  DATA_W  combinational read data from memory/peripheral mux

Behaviour:
- Request definitions: cpu_req = cpu_re_i|cpu_we_i; dma_req = dma_re_i|dma_we_i.
- Requester contract: a requester holds its request and address/data stable until granted. The CPU meets this by being frozen by CTRL while stalled.
- Grant is combinational from the registered state plus the current requests. At most one grant per cycle.
- Bus mux:
  - The granted requester's strobes, address and write data drive bus_*.
  - No grant: bus_re_o = bus_we_o = 0; bus_addr_o and bus_wdata_o = 0.
  - Strobes pass unmodified; re&we together from one requester is illegal and is not checked.
- State machine: S_CPU (default), S_DMA. burst_cnt is 0 to MAX_BURST; starve_cnt is 0 to STARVE_LIMIT, saturating.
- S_CPU, evaluated in priority order:
  1. dma_req & starve_cnt==STARVE_LIMIT: grant DMA for one slot; starve_cnt<=0; stay S_CPU.
  2. cpu_req: grant CPU; starve_cnt<=starve_cnt+1 (saturating) if dma_req, else 0.
  3. dma_req only: grant DMA; burst_cnt<=1; go S_DMA; starve_cnt<=0.
  4. Otherwise: idle; starve_cnt<=0.
- S_DMA:
  - dma_req & burst_cnt<MAX_BURST: grant DMA; burst_cnt++.
  - Otherwise: grant CPU if cpu_req; burst_cnt<=0; starve_cnt<=0; go S_CPU.
- Outputs derived from grant:
  - cpu_stallreq_o = cpu_req & ~cpu_gnt (combinational).
  - dma_gnt_o = DMA grant (combinational).
- DMA read return: on a DMA read grant, dma_rdata_o<=bus_rdata_i and dma_rvalid_o<=1 at the next edge. Otherwise dma_rvalid_o<=0, and dma_rdata_o holds its value.
- CPU read data: cpu_rdata_o = bus_rdata_i whenever the CPU is granted (zero-latency, as the MEM stage requires); 0 otherwise.
- Worst-case waits:
  - CPU: MAX_BURST cycles after a DMA burst starts.
  - DMA: STARVE_LIMIT+1 cycles under continuous CPU traffic.
- Reset, including mid-burst: state<=S_CPU, burst_cnt<=0, starve_cnt<=0, dma_rdata_o<=0, dma_rvalid_o<=0. While rst=1, all combinational outputs (grants, bus_*, cpu_stallreq_o, cpu_rdata_o) are forced to 0. A DMA read granted in the cycle before reset asserts yields no rvalid.

Test Plan:
- CPU read alone, addr 0x10, bus_rdata_i=0xDEADBEEF -> same cycle: bus_re_o=1, bus_addr_o=0x10, cpu_rdata_o=0xDEADBEEF, cpu_stallreq_o=0.
- DMA writes 0x20..0x2C while CPU idle for 6 cycles -> 4 consecutive dma_gnt_o; 5th cycle is a forced return to S_CPU with no grant; DMA regranted on the 6th cycle (new burst).
- CPU requests during a DMA burst at burst_cnt=2 -> cpu_stallreq_o=1 for 2 cycles; CPU granted on cycle 3; stall deasserts.
- CPU and DMA both request continuously -> DMA granted on every 4th cycle (after 3 denials); cpu_stallreq_o=1 exactly on those cycles.
- DMA read of 0x40 with bus_rdata_i=0x12345678 -> next cycle dma_rvalid_o=1 and dma_rdata_o=0x12345678; the cycle after, dma_rvalid_o=0.
- rst asserted mid-burst at burst_cnt=3 with a read granted -> next cycle: state S_CPU, dma_rvalid_o=0, all bus_* 0. After rst drops, a lone CPU request is granted immediately.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares the single data-memory / peripheral bus between the CPU MEM stage and
// a DMA/loader port. The CPU normally wins. Two bounds keep either side from
// waiting too long:
//   - a DMA burst that started while the CPU was idle ends after MAX_BURST
//     grants, and the arbiter then returns to CPU priority;
//   - a starvation counter forces one DMA slot after STARVE_LIMIT denied
//     DMA-request cycles.
// The CPU is stalled through CTRL whenever it requests and is not granted.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   cpu_re_i/we_i       CPU read/write strobes (MEM stage)
//   cpu_addr_i/wdata_i  CPU address / write data
//   cpu_rdata_o         CPU read data, combinational from bus_rdata_i when granted
//   cpu_stallreq_o      CPU requested but was not granted this cycle
//   dma_re_i/we_i       DMA read/write strobes
//   dma_addr_i/wdata_i  DMA address / write data
//   dma_gnt_o           DMA access performed this cycle
//   dma_rdata_o         registered DMA read data
//   dma_rvalid_o        one-cycle pulse qualifying dma_rdata_o
//   bus_re_o/we_o       shared read/write enables
//   bus_addr_o/wdata_o  shared address / write data
//   bus_rdata_i         combinational read data from the memory/peripheral mux
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_BURST    = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              cpu_re_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_stallreq_o,

  input  logic              dma_re_i,
  input  logic              dma_we_i,
  input  logic [ADDR_W-1:0] dma_addr_i,
  input  logic [DATA_W-1:0] dma_wdata_i,
  output logic              dma_gnt_o,
  output logic [DATA_W-1:0] dma_rdata_o,
  output logic              dma_rvalid_o,

  output logic              bus_re_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic [DATA_W-1:0] bus_rdata_i
);

  localparam int BURST_W  = $clog2(MAX_BURST + 1);
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  localparam logic [BURST_W-1:0]  BURST_MAX  = BURST_W'(MAX_BURST);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  typedef enum logic {
    S_CPU = 1'b0,
    S_DMA = 1'b1
  } state_t;

  state_t               r_state,      w_state_nxt;
  logic [BURST_W-1:0]   r_burst_cnt,  w_burst_nxt;
  logic [STARVE_W-1:0]  r_starve_cnt, w_starve_nxt;
  logic [DATA_W-1:0]    r_dma_rdata;
  logic                 r_dma_rvalid;

  logic w_cpu_req;
  logic w_dma_req;
  logic w_cpu_gnt_raw;
  logic w_dma_gnt_raw;
  logic w_cpu_gnt;
  logic w_dma_gnt;
  logic w_dma_rd_gnt;

  assign w_cpu_req = cpu_re_i | cpu_we_i;
  assign w_dma_req = dma_re_i | dma_we_i;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_CPU;
      r_burst_cnt  <= '0;
      r_starve_cnt <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_burst_cnt  <= w_burst_nxt;
      r_starve_cnt <= w_starve_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and grant decision
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path through
  // the case/if tree leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt   = r_state;
    w_burst_nxt   = r_burst_cnt;
    w_starve_nxt  = r_starve_cnt;
    w_cpu_gnt_raw = 1'b0;
    w_dma_gnt_raw = 1'b0;

    unique case (r_state)
      S_CPU: begin
        if (w_dma_req && (r_starve_cnt == STARVE_MAX)) begin
          // DMA has waited long enough: one forced slot, CPU priority resumes.
          w_dma_gnt_raw = 1'b1;
          w_starve_nxt  = '0;
        end else if (w_cpu_req) begin
          w_cpu_gnt_raw = 1'b1;
          if (w_dma_req) begin
            if (r_starve_cnt != STARVE_MAX) begin
              w_starve_nxt = r_starve_cnt + STARVE_W'(1);
            end
          end else begin
            w_starve_nxt = '0;
          end
        end else if (w_dma_req) begin
          // CPU idle: DMA starts a burst.
          w_dma_gnt_raw = 1'b1;
          w_burst_nxt   = BURST_W'(1);
          w_state_nxt   = S_DMA;
          w_starve_nxt  = '0;
        end else begin
          w_starve_nxt = '0;
        end
      end

      S_DMA: begin
        if (w_dma_req && (r_burst_cnt < BURST_MAX)) begin
          w_dma_gnt_raw = 1'b1;
          w_burst_nxt   = r_burst_cnt + BURST_W'(1);
        end else begin
          // Burst exhausted or DMA done: hand the slot back to the CPU. When
          // the limit is hit with the CPU idle this cycle carries no grant.
          w_cpu_gnt_raw = w_cpu_req;
          w_burst_nxt   = '0;
          w_starve_nxt  = '0;
          w_state_nxt   = S_CPU;
        end
      end

      default: begin
        w_state_nxt = S_CPU;
      end
    endcase
  end

  // Reset forces every combinational output low, including the grants.
  assign w_cpu_gnt    = w_cpu_gnt_raw & ~rst;
  assign w_dma_gnt    = w_dma_gnt_raw & ~rst;
  assign w_dma_rd_gnt = w_dma_gnt & dma_re_i;

  // ---------------------------------------------------------------------------
  // Bus mux
  // ---------------------------------------------------------------------------
  always_comb begin
    bus_re_o    = 1'b0;
    bus_we_o    = 1'b0;
    bus_addr_o  = '0;
    bus_wdata_o = '0;
    if (w_cpu_gnt) begin
      bus_re_o    = cpu_re_i;
      bus_we_o    = cpu_we_i;
      bus_addr_o  = cpu_addr_i;
      bus_wdata_o = cpu_wdata_i;
    end else if (w_dma_gnt) begin
      bus_re_o    = dma_re_i;
      bus_we_o    = dma_we_i;
      bus_addr_o  = dma_addr_i;
      bus_wdata_o = dma_wdata_i;
    end
  end

  assign cpu_rdata_o    = w_cpu_gnt ? bus_rdata_i : '0;
  assign cpu_stallreq_o = w_cpu_req & ~w_cpu_gnt & ~rst;
  assign dma_gnt_o      = w_dma_gnt;

  // ---------------------------------------------------------------------------
  // DMA read return: capture on the edge that ends a granted DMA read.
  // ---------------------------------------------------------------------------
  // NOTE: the read-data register is reset even though rvalid alone qualifies
  // it, so the DMA side never observes stale data from before reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dma_rdata  <= '0;
      r_dma_rvalid <= 1'b0;
    end else begin
      r_dma_rvalid <= w_dma_rd_gnt;
      if (w_dma_rd_gnt) begin
        r_dma_rdata <= bus_rdata_i;
      end
    end
  end

  assign dma_rdata_o  = r_dma_rdata;
  assign dma_rvalid_o = r_dma_rvalid;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
//
// Directed bench for mem_bus_arbiter (default parameters: MAX_BURST=4,
// STARVE_LIMIT=3). Inputs change 1 time unit after the rising edge; outputs
// are sampled on the falling edge. Expected values are hand-computed.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk;
  logic              rst;
  logic              cpu_re, cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stallreq;
  logic              dma_re, dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt;
  logic [DATA_W-1:0] dma_rdata;
  logic              dma_rvalid;
  logic              bus_re, bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  mem_bus_arbiter #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .MAX_BURST   (4),
    .STARVE_LIMIT(3)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cpu_re_i      (cpu_re),
    .cpu_we_i      (cpu_we),
    .cpu_addr_i    (cpu_addr),
    .cpu_wdata_i   (cpu_wdata),
    .cpu_rdata_o   (cpu_rdata),
    .cpu_stallreq_o(cpu_stallreq),
    .dma_re_i      (dma_re),
    .dma_we_i      (dma_we),
    .dma_addr_i    (dma_addr),
    .dma_wdata_i   (dma_wdata),
    .dma_gnt_o     (dma_gnt),
    .dma_rdata_o   (dma_rdata),
    .dma_rvalid_o  (dma_rvalid),
    .bus_re_o      (bus_re),
    .bus_we_o      (bus_we),
    .bus_addr_o    (bus_addr),
    .bus_wdata_o   (bus_wdata),
    .bus_rdata_i   (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog: the sequence below is a few hundred ns long.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_tests++;
    assert (observed === expected) else begin
      n_fail++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      $error("check %s did not match", tag);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_re    = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    dma_re    = 1'b0;
    dma_we    = 1'b0;
    dma_addr  = '0;
    dma_wdata = '0;
  endtask

  logic [31:0] exp_addr;
  logic        exp_g;
  int          n_granted;

  initial begin
    // ---------------- Reset, with requests present ----------------
    rst       = 1'b1;
    idle_inputs();
    cpu_re    = 1'b1;
    cpu_addr  = 32'h0000_0004;
    dma_re    = 1'b1;
    dma_addr  = 32'h0000_0008;
    bus_rdata = 32'hFFFF_FFFF;
    next_cycle();
    @(negedge clk);
    check("rst_bus_re",    {31'd0, bus_re},       32'd0);
    check("rst_bus_addr",  bus_addr,              32'd0);
    check("rst_cpu_stall", {31'd0, cpu_stallreq}, 32'd0);
    check("rst_dma_gnt",   {31'd0, dma_gnt},      32'd0);
    check("rst_cpu_rdata", cpu_rdata,             32'd0);
    check("rst_rvalid",    {31'd0, dma_rvalid},   32'd0);
    check("rst_rdata",     dma_rdata,             32'd0);
    next_cycle();
    rst = 1'b0;
    idle_inputs();

    // ---------------- 1: CPU read alone ----------------
    cpu_re    = 1'b1;
    cpu_addr  = 32'h0000_0010;
    bus_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("t1_bus_re",    {31'd0, bus_re},       32'd1);
    check("t1_bus_we",    {31'd0, bus_we},       32'd0);
    check("t1_bus_addr",  bus_addr,              32'h0000_0010);
    check("t1_cpu_rdata", cpu_rdata,             32'hDEAD_BEEF);
    check("t1_cpu_stall", {31'd0, cpu_stallreq}, 32'd0);
    check("t1_dma_gnt",   {31'd0, dma_gnt},      32'd0);
    next_cycle();
    idle_inputs();

    // ---------------- 2: DMA writes, CPU idle, 6 cycles ----------------
    // Grants on cycles 0-3 (0x20..0x2C), none on 4, new burst on 5 (0x30).
    dma_we    = 1'b1;
    dma_addr  = 32'h0000_0020;
    dma_wdata = 32'h0000_00A0;
    n_granted = 0;
    for (int i = 0; i < 6; i++) begin
      exp_g    = (i != 4);
      exp_addr = exp_g ? 32'h0000_0020 + 32'(4 * n_granted) : 32'd0;
      @(negedge clk);
      check($sformatf("t2_dma_gnt_c%0d", i), {31'd0, dma_gnt},  {31'd0, exp_g});
      check($sformatf("t2_bus_we_c%0d", i),  {31'd0, bus_we},   {31'd0, exp_g});
      check($sformatf("t2_bus_addr_c%0d", i), bus_addr,          exp_addr);
      next_cycle();
      if (exp_g) begin
        n_granted++;
        dma_addr  = dma_addr + 32'd4;
        dma_wdata = dma_wdata + 32'd1;
      end
    end
    // Writes never produce a read-valid pulse.
    check("t2_rvalid", {31'd0, dma_rvalid}, 32'd0);
    idle_inputs();
    @(negedge clk);
    check("t2_idle_gnt", {31'd0, dma_gnt}, 32'd0);
    next_cycle();

    // ---------------- 3: CPU arrives at burst_cnt=2 ----------------
    dma_we    = 1'b1;
    dma_addr  = 32'h0000_0060;
    next_cycle();   // S_CPU -> DMA grant, burst 1
    next_cycle();   // S_DMA burst 1 -> grant, burst 2
    cpu_we    = 1'b1;
    cpu_addr  = 32'h0000_0080;
    cpu_wdata = 32'h0000_0055;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check($sformatf("t3_stall_c%0d", i),   {31'd0, cpu_stallreq}, 32'd1);
      check($sformatf("t3_dma_gnt_c%0d", i), {31'd0, dma_gnt},      32'd1);
      next_cycle();
    end
    @(negedge clk);
    check("t3_stall_c2",   {31'd0, cpu_stallreq}, 32'd0);
    check("t3_dma_gnt_c2", {31'd0, dma_gnt},      32'd0);
    check("t3_bus_we_c2",  {31'd0, bus_we},       32'd1);
    check("t3_bus_addr",   bus_addr,              32'h0000_0080);
    check("t3_bus_wdata",  bus_wdata,             32'h0000_0055);
    next_cycle();
    idle_inputs();
    next_cycle();

    // ---------------- 4: continuous contention ----------------
    cpu_re    = 1'b1;
    cpu_addr  = 32'h0000_0100;
    dma_we    = 1'b1;
    dma_addr  = 32'h0000_0200;
    for (int i = 0; i < 8; i++) begin
      exp_g    = ((i % 4) == 3);
      exp_addr = exp_g ? 32'h0000_0200 : 32'h0000_0100;
      @(negedge clk);
      check($sformatf("t4_dma_gnt_c%0d", i), {31'd0, dma_gnt},      {31'd0, exp_g});
      check($sformatf("t4_stall_c%0d", i),   {31'd0, cpu_stallreq}, {31'd0, exp_g});
      check($sformatf("t4_bus_addr_c%0d", i), bus_addr,              exp_addr);
      next_cycle();
    end
    idle_inputs();
    next_cycle();

    // ---------------- 5: DMA read return ----------------
    dma_re    = 1'b1;
    dma_addr  = 32'h0000_0040;
    bus_rdata = 32'h1234_5678;
    @(negedge clk);
    check("t5_dma_gnt",   {31'd0, dma_gnt}, 32'd1);
    check("t5_bus_re",    {31'd0, bus_re},  32'd1);
    check("t5_bus_addr",  bus_addr,         32'h0000_0040);
    check("t5_cpu_rdata", cpu_rdata,        32'd0);
    next_cycle();
    idle_inputs();
    bus_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    check("t5_rvalid_1", {31'd0, dma_rvalid}, 32'd1);
    check("t5_rdata_1",  dma_rdata,           32'h1234_5678);
    next_cycle();
    @(negedge clk);
    check("t5_rvalid_2", {31'd0, dma_rvalid}, 32'd0);
    check("t5_rdata_2",  dma_rdata,           32'h1234_5678);
    next_cycle();

    // ---------------- 6: reset mid-burst at burst_cnt=3 ----------------
    dma_re    = 1'b1;
    dma_addr  = 32'h0000_0300;
    bus_rdata = 32'hCAFE_0001;
    next_cycle();   // burst 1
    next_cycle();   // burst 2
    next_cycle();   // burst 3
    @(negedge clk);
    check("t6_gnt_b3", {31'd0, dma_gnt}, 32'd1);
    rst = 1'b1;     // raised before the edge that would capture this read
    next_cycle();
    @(negedge clk);
    check("t6_rvalid",   {31'd0, dma_rvalid}, 32'd0);
    check("t6_bus_re",   {31'd0, bus_re},     32'd0);
    check("t6_bus_addr", bus_addr,            32'd0);
    check("t6_dma_gnt",  {31'd0, dma_gnt},    32'd0);
    next_cycle();
    rst = 1'b0;
    // DMA still requesting: a CPU win here shows the burst state was cleared.
    cpu_we    = 1'b1;
    cpu_addr  = 32'h0000_0044;
    cpu_wdata = 32'h0000_0077;
    @(negedge clk);
    check("t6_cpu_bus_we", {31'd0, bus_we},       32'd1);
    check("t6_cpu_addr",   bus_addr,              32'h0000_0044);
    check("t6_cpu_stall",  {31'd0, cpu_stallreq}, 32'd0);
    check("t6_dma_denied", {31'd0, dma_gnt},      32'd0);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("t6_no_rvalid", {31'd0, dma_rvalid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
